// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer arbiter slice.
// Grant and game-FSM encodings plus the write-queue entry layout.
package fb_pkg;

  localparam int FB_AW = 10;
  localparam int FB_DW = 4;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_VGA,
    GNT_GRD,
    GNT_GWR
  } gnt_t;

  typedef enum logic [1:0] {
    G_IDLE,
    G_RDWAIT,
    G_RDDATA
  } gstate_t;

  typedef struct packed {
    logic [FB_AW-1:0] addr;
    logic [FB_DW-1:0] wdata;
  } wq_entry_t;

endpackage

// File: rtl/fb_sync_fifo.sv
// Small synchronous FIFO with full/empty/count, used as the game write queue.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter  int WIDTH = 14,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: VGA scan-out wins during active video,
// game writes are queued and drained in idle cycles, game reads wait for the queue.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter  int AW       = FB_AW,
  parameter  int DW       = FB_DW,
  parameter  int WQ_DEPTH = 4,
  localparam int CW       = $clog2(WQ_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vga_re,
  input  logic          vga_blank,
  input  logic [AW-1:0] vga_raddr,
  output logic [DW-1:0] vga_rdata,
  output logic          vga_rvalid,
  input  logic          g_valid,
  output logic          g_ready,
  input  logic          g_we,
  input  logic [AW-1:0] g_addr,
  input  logic [DW-1:0] g_wdata,
  output logic [DW-1:0] g_rdata,
  output logic          g_rvalid,
  output logic [CW-1:0] wq_count,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  gstate_t          state_q, state_d;
  gnt_t             gnt, gnt_q;
  logic [AW-1:0]    rd_addr_q, rd_addr_d;
  logic [DW-1:0]    g_rdata_q, g_rdata_d;
  logic             wq_full, wq_empty, wq_push, wq_pop;
  logic [AW+DW-1:0] wq_rdata;

  assign g_ready = (state_q == G_IDLE) & (g_we ? ~wq_full : wq_empty);
  assign wq_push = g_valid & g_ready & g_we;
  assign wq_pop  = (gnt == GNT_GWR);

  sync_fifo #(
    .WIDTH (AW + DW),
    .DEPTH (WQ_DEPTH)
  ) u_wq (
    .clk   (clk),
    .reset (reset),
    .push  (wq_push),
    .wdata ({g_addr, g_wdata}),
    .pop   (wq_pop),
    .rdata (wq_rdata),
    .full  (wq_full),
    .empty (wq_empty),
    .count (wq_count)
  );

  // Grant is forced idle while reset is held so no RAM access escapes a reset cycle.
  always_comb begin
    gnt = GNT_NONE;
    if (!reset) begin
      if (vga_re && !vga_blank)    gnt = GNT_VGA;
      else if (state_q == G_RDWAIT) gnt = GNT_GRD;
      else if (!wq_empty)          gnt = GNT_GWR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= G_IDLE;
      gnt_q     <= GNT_NONE;
      rd_addr_q <= '0;
      g_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt;
      rd_addr_q <= rd_addr_d;
      g_rdata_q <= g_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    g_rdata_d = g_rdata_q;
    case (state_q)
      G_IDLE: begin
        if (g_valid && g_ready && !g_we) begin
          state_d   = G_RDWAIT;
          rd_addr_d = g_addr;
        end
      end
      G_RDWAIT: begin
        if (gnt == GNT_GRD) state_d = G_RDDATA;
      end
      G_RDDATA: begin
        g_rdata_d = mem_rdata;
        state_d   = G_IDLE;
      end
      default: state_d = G_IDLE;
    endcase
  end

  // Read data is forwarded straight from the RAM in the return cycle, then held.
  always_comb begin
    g_rvalid   = (state_q == G_RDDATA);
    g_rdata    = g_rvalid ? mem_rdata : g_rdata_q;
    vga_rvalid = (gnt_q == GNT_VGA);
    vga_rdata  = mem_rdata;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (gnt)
      GNT_VGA: begin
        mem_en   = 1'b1;
        mem_addr = vga_raddr;
      end
      GNT_GRD: begin
        mem_en   = 1'b1;
        mem_addr = rd_addr_q;
      end
      GNT_GWR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wq_rdata[AW+DW-1:DW];
        mem_wdata = wq_rdata[DW-1:0];
      end
      default: ;
    endcase
  end

endmodule
